// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-style control FSM with memory handshake, wait timeout and bus error.
// Define MC_CTRL_PERF_EN to add the cyc_cnt / instr_cnt performance counters.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        OPCode,
    input  logic [5:0]        Funct,
    input  logic              Zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              IorD,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegDst,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic              PCEn,
    output logic [1:0]        PCSrc,
    output logic [1:0]        ALUSrcB,
    output logic [2:0]        ALUControl,
    output logic              illegal_op,
    output logic              bus_err
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] cyc_cnt,
    output logic [PERF_W-1:0] instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic       pcen;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [2:0] aluctl;
    } ctl_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_reg, state_next;
    ctl_t       ctl_reg;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       mem_req_reg, mem_req_next;
    logic       bus_err_reg;
    logic       mem_ok, timeout;
    logic       opcode_ok, funct_ok;
    logic [2:0] alu_funct;
    logic       fetch_done, branch_take;

    // Purely state-dependent controls; registered from the next state.
    function automatic ctl_t moore_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.alusrcb = 2'b01; c.aluctl = 3'b010; end
            S_DECODE:   begin c.alusrcb = 2'b11; c.aluctl = 3'b010; end
            S_MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluctl = 3'b010; end
            S_MEMREAD:  c.iord = 1'b1;
            S_MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWRITE: begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXECUTE:  c.alusrca = 1'b1;
            S_ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_BRANCH:   begin c.alusrca = 1'b1; c.aluctl = 3'b110; c.pcsrc = 2'b01; end
            S_ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluctl = 3'b010; end
            S_ADDIWB:   c.regwrite = 1'b1;
            S_JUMP:     begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

    always_comb begin
        opcode_ok = 1'b1;
        case (OPCode)
            6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02: opcode_ok = 1'b1;
            default:                                         opcode_ok = 1'b0;
        endcase
        funct_ok  = 1'b1;
        alu_funct = 3'b000;
        case (Funct)
            6'h20:   alu_funct = 3'b010;
            6'h22:   alu_funct = 3'b110;
            6'h24:   alu_funct = 3'b000;
            6'h25:   alu_funct = 3'b001;
            6'h2A:   alu_funct = 3'b111;
            default: funct_ok  = 1'b0;
        endcase
    end

    // mem_ready only counts while a request is actually on the bus.
    assign mem_ok  = mem_req_reg & mem_ready;
    assign timeout = mem_req_reg & ~mem_ready & (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (mem_ok) state_next = S_DECODE;
            S_DECODE: begin
                case (OPCode)
                    6'h23, 6'h2B: state_next = S_MEMADR;
                    6'h00:        state_next = S_EXECUTE;
                    6'h04, 6'h05: state_next = S_BRANCH;
                    6'h08:        state_next = S_ADDIEXEC;
                    6'h02:        state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (OPCode == 6'h2B) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ok) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ok) state_next = S_FETCH;
            S_EXECUTE:  state_next = funct_ok ? S_ALUWB : S_FETCH;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_ADDIEXEC: state_next = S_ADDIWB;
            S_ADDIWB:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
        if (timeout) state_next = S_FETCH;
        // After a timeout the bus is released for one cycle before FETCH re-requests.
        mem_req_next  = ~timeout & is_mem_state(state_next);
        wait_cnt_next = (mem_req_reg & ~mem_ready & ~timeout) ? wait_cnt_reg + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_FETCH;
            ctl_reg      <= moore_ctl(S_FETCH);
            wait_cnt_reg <= 8'd0;
            mem_req_reg  <= 1'b1;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ctl_reg      <= moore_ctl(state_next);
            wait_cnt_reg <= wait_cnt_next;
            mem_req_reg  <= mem_req_next;
            bus_err_reg  <= timeout;
        end
    end

    // Reset gating keeps the fetch strobes quiet while reset is held.
    assign fetch_done  = (state_reg == S_FETCH) & mem_ok & reset;
    assign branch_take = (state_reg == S_BRANCH) & (OPCode[0] ? ~Zero : Zero);

    assign mem_req    = mem_req_reg;
    assign IorD       = ctl_reg.iord;
    assign MemWrite   = ctl_reg.memwrite;
    assign IRWrite    = fetch_done;
    assign RegDst     = ctl_reg.regdst;
    assign MemtoReg   = ctl_reg.memtoreg;
    assign RegWrite   = ctl_reg.regwrite;
    assign ALUSrcA    = ctl_reg.alusrca;
    assign PCEn       = ctl_reg.pcen | fetch_done | branch_take;
    assign PCSrc      = ctl_reg.pcsrc;
    assign ALUSrcB    = ctl_reg.alusrcb;
    assign ALUControl = (state_reg == S_EXECUTE) ? alu_funct : ctl_reg.aluctl;
    assign illegal_op = ((state_reg == S_DECODE) & ~opcode_ok) |
                        ((state_reg == S_EXECUTE) & ~funct_ok);
    assign bus_err    = bus_err_reg;

`ifdef MC_CTRL_PERF_EN
    logic [PERF_W-1:0] cyc_cnt_reg, instr_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt_reg   <= '0;
            instr_cnt_reg <= '0;
        end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
            if (fetch_done) instr_cnt_reg <= instr_cnt_reg + 1'b1;
        end
    end

    assign cyc_cnt   = cyc_cnt_reg;
    assign instr_cnt = instr_cnt_reg;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: expected per-cycle control vectors are queued as
// stimulus is driven and compared on the falling edge.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;

    localparam int TO = 4;
    localparam int PW = 16;

    typedef enum {T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                  T_EXECUTE, T_ALUWB, T_BRANCH, T_ADDIEXEC, T_ADDIWB, T_JUMP} tst_t;

    typedef struct {
        string       tag;
        logic [17:0] exp;
        int unsigned cyc;
        int unsigned instr;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] OPCode, Funct;
    logic Zero, mem_ready;
    logic mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUControl;
    logic illegal_op, bus_err;
`ifdef MC_CTRL_PERF_EN
    logic [PW-1:0] cyc_cnt, instr_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_cyc = 0;
    int unsigned exp_instr = 0;
    bit in_reset = 1'b1;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_TIMEOUT(TO), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset), .OPCode(OPCode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .illegal_op(illegal_op), .bus_err(bus_err)
`ifdef MC_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference control vector from the state table:
    // {mem_req,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,PCEn,PCSrc,ALUSrcB,ALUControl,illegal_op,bus_err}
    function automatic logic [17:0] ref_vec(input tst_t st, input logic rdy, input logic z,
                                            input logic [5:0] op, input logic [5:0] fn,
                                            input logic abort);
        logic req, iord, mw, irw, rd, m2r, rw, sa, pce, ill, be;
        logic [1:0] ps, sb;
        logic [2:0] ac;
        {req, iord, mw, irw, rd, m2r, rw, sa, pce, ill, be} = '0;
        ps = 2'b00; sb = 2'b00; ac = 3'b000;
        case (st)
            T_FETCH: begin
                req = ~abort; be = abort; sb = 2'b01; ac = 3'b010;
                irw = rdy & ~abort; pce = rdy & ~abort;
            end
            T_DECODE: begin
                sb = 2'b11; ac = 3'b010;
                ill = !(op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 ||
                        op == 6'h05 || op == 6'h08 || op == 6'h02);
            end
            T_MEMADR:   begin sa = 1'b1; sb = 2'b10; ac = 3'b010; end
            T_MEMREAD:  begin req = 1'b1; iord = 1'b1; end
            T_MEMWB:    begin m2r = 1'b1; rw = 1'b1; end
            T_MEMWRITE: begin req = 1'b1; iord = 1'b1; mw = 1'b1; end
            T_EXECUTE: begin
                sa = 1'b1;
                case (fn)
                    6'h20: ac = 3'b010;
                    6'h22: ac = 3'b110;
                    6'h24: ac = 3'b000;
                    6'h25: ac = 3'b001;
                    6'h2A: ac = 3'b111;
                    default: ill = 1'b1;
                endcase
            end
            T_ALUWB:    begin rd = 1'b1; rw = 1'b1; end
            T_BRANCH:   begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pce = (op == 6'h04) ? z : ~z; end
            T_ADDIEXEC: begin sa = 1'b1; sb = 2'b10; ac = 3'b010; end
            T_ADDIWB:   rw = 1'b1;
            T_JUMP:     begin ps = 2'b10; pce = 1'b1; end
            default:    req = 1'b0;
        endcase
        return {req, iord, mw, irw, rd, m2r, rw, sa, pce, ps, sb, ac, ill, be};
    endfunction

    // One clock cycle: drive mem_ready, queue the expectation, advance to posedge+1.
    task automatic cyc(input string tag, input tst_t st, input logic rdy, input logic abort);
        sb_t e;
        mem_ready = rdy;
        e.tag   = tag;
        e.exp   = ref_vec(st, rdy & ~in_reset, Zero, OPCode, Funct, abort);
        e.cyc   = exp_cyc;
        e.instr = exp_instr;
        sb_q.push_back(e);
        if (!in_reset) begin
            exp_cyc++;
            if (st == T_FETCH && rdy && !abort) exp_instr++;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            check(e.tag, 32'({mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                              ALUSrcA, PCEn, PCSrc, ALUSrcB, ALUControl, illegal_op, bus_err}),
                  32'(e.exp));
`ifdef MC_CTRL_PERF_EN
            check({e.tag, "_cyc"}, 32'(cyc_cnt), 32'(e.cyc));
            check({e.tag, "_instr"}, 32'(instr_cnt), 32'(e.instr));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] fn_tab [4];
    logic [5:0] br_op  [4];
    logic       br_z   [4];

    initial begin
        fn_tab = '{6'h22, 6'h24, 6'h25, 6'h2A};
        br_op  = '{6'h05, 6'h04, 6'h04, 6'h05};
        br_z   = '{1'b0, 1'b0, 1'b1, 1'b1};
        reset = 1'b0; OPCode = 6'h00; Funct = 6'h20; Zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        // Reset held with mem_ready high: strobes must stay low.
        cyc("rst0", T_FETCH, 1'b1, 1'b0);
        cyc("rst1", T_FETCH, 1'b1, 1'b0);
        reset = 1'b1; in_reset = 1'b0;

        // lw, memory ready at once; mem_ready during MEMADR is ignored
        OPCode = 6'h23;
        cyc("lw_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("lw_dec", T_DECODE, 1'b0, 1'b0);
        cyc("lw_adr", T_MEMADR, 1'b1, 1'b0);
        cyc("lw_read", T_MEMREAD, 1'b1, 1'b0);
        cyc("lw_wb", T_MEMWB, 1'b0, 1'b0);

        // add with fetch delayed 3 cycles (completes at the timeout boundary)
        OPCode = 6'h00; Funct = 6'h20;
        for (int i = 0; i < 3; i++) cyc("add_fwait", T_FETCH, 1'b0, 1'b0);
        cyc("add_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("add_dec", T_DECODE, 1'b0, 1'b0);
        cyc("add_exec", T_EXECUTE, 1'b0, 1'b0);
        cyc("add_wb", T_ALUWB, 1'b0, 1'b0);

        // remaining R-type functions
        for (int i = 0; i < 4; i++) begin
            Funct = fn_tab[i];
            cyc("r_fetch", T_FETCH, 1'b1, 1'b0);
            cyc("r_dec", T_DECODE, 1'b0, 1'b0);
            cyc($sformatf("r_exec_%h", fn_tab[i]), T_EXECUTE, 1'b0, 1'b0);
            cyc("r_wb", T_ALUWB, 1'b0, 1'b0);
        end

        // branches: bne/beq with Zero 0 and 1
        for (int i = 0; i < 4; i++) begin
            OPCode = br_op[i]; Zero = br_z[i];
            cyc("br_fetch", T_FETCH, 1'b1, 1'b0);
            cyc("br_dec", T_DECODE, 1'b0, 1'b0);
            cyc($sformatf("br_%h_z%0d", br_op[i], br_z[i]), T_BRANCH, 1'b0, 1'b0);
        end
        Zero = 1'b0;

        // sw that never completes: bus_err after TO cycles, bus released one cycle
        OPCode = 6'h2B;
        cyc("sw_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("sw_dec", T_DECODE, 1'b0, 1'b0);
        cyc("sw_adr", T_MEMADR, 1'b0, 1'b0);
        for (int i = 0; i < TO; i++) cyc("sw_wait", T_MEMWRITE, 1'b0, 1'b0);
        cyc("sw_abort", T_FETCH, 1'b1, 1'b0 | 1'b1);

        // lw whose data arrives exactly when the wait count hits the limit
        OPCode = 6'h23;
        cyc("lwb_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("lwb_dec", T_DECODE, 1'b0, 1'b0);
        cyc("lwb_adr", T_MEMADR, 1'b0, 1'b0);
        for (int i = 0; i < TO - 1; i++) cyc("lwb_wait", T_MEMREAD, 1'b0, 1'b0);
        cyc("lwb_read", T_MEMREAD, 1'b1, 1'b0);
        cyc("lwb_wb", T_MEMWB, 1'b0, 1'b0);

        // illegal opcode, then illegal function
        OPCode = 6'h3F;
        cyc("ill_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("ill_dec", T_DECODE, 1'b0, 1'b0);
        OPCode = 6'h00; Funct = 6'h3F;
        cyc("badf_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("badf_dec", T_DECODE, 1'b0, 1'b0);
        cyc("badf_exec", T_EXECUTE, 1'b0, 1'b0);

        // addi and jump
        OPCode = 6'h08;
        cyc("addi_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("addi_dec", T_DECODE, 1'b0, 1'b0);
        cyc("addi_exec", T_ADDIEXEC, 1'b0, 1'b0);
        cyc("addi_wb", T_ADDIWB, 1'b0, 1'b0);
        OPCode = 6'h02;
        cyc("j_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("j_dec", T_DECODE, 1'b0, 1'b0);
        cyc("j_jump", T_JUMP, 1'b0, 1'b0);

        // fetch timeout retries the fetch
        OPCode = 6'h23;
        for (int i = 0; i < TO; i++) cyc("ft_wait", T_FETCH, 1'b0, 1'b0);
        cyc("ft_abort", T_FETCH, 1'b1, 1'b1);
        cyc("ft_retry", T_FETCH, 1'b1, 1'b0);
        cyc("rm_dec", T_DECODE, 1'b0, 1'b0);
        cyc("rm_adr", T_MEMADR, 1'b0, 1'b0);
        cyc("rm_read", T_MEMREAD, 1'b0, 1'b0);

        // reset in the middle of a pending read
        reset = 1'b0; in_reset = 1'b1; exp_cyc = 0; exp_instr = 0;
        cyc("rm_rst", T_FETCH, 1'b1, 1'b0);
        reset = 1'b1; in_reset = 1'b0;
        cyc("rm_post0", T_FETCH, 1'b0, 1'b0);
        cyc("rm_post1", T_FETCH, 1'b1, 1'b0);
        cyc("rm_post_dec", T_DECODE, 1'b0, 1'b0);

        @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max wait cycles for mem_ready (range 1..255).
REQ-002 SHALL have parameter PERF_W, default 32, width of performance counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports OPCode  input  6, Funct  input  6, Zero  input  1  (from datapath).
REQ-006 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-007 SHALL have port mem_req  output  1  memory access requested (fetch, load, store).
REQ-008 SHALL have outputs IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn (1 each), PCSrc (2), ALUSrcB (2), ALUControl (3).
REQ-009 SHALL have outputs illegal_op  1  and bus_err  1, each a one-cycle pulse.
REQ-010 SHALL have outputs cyc_cnt  PERF_W  and instr_cnt  PERF_W (present only per REQ-029).

Function
REQ-011 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP; Moore outputs except where noted.
REQ-012 FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00; IRWrite=PCEn=1 only in the cycle mem_ready=1, which advances to DECODE.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010; next by OPCode: 23h/2Bh->MEMADR, 00h->EXECUTE, 04h/05h->BRANCH, 08h->ADDIEXEC, 02h->JUMP, other->FETCH with illegal_op pulse.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010; 23h->MEMREAD, 2Bh->MEMWRITE.
REQ-015 MEMREAD: mem_req=1, IorD=1; advance to MEMWB on mem_ready. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; ->FETCH.
REQ-016 MEMWRITE: mem_req=1, IorD=1, MemWrite=1; ->FETCH on mem_ready.
REQ-017 EXECUTE: ALUSrcA=1, ALUSrcB=00; Funct 20h->010, 22h->110, 24h->000, 25h->001, 2Ah->111; ->ALUWB; unknown Funct ->FETCH with illegal_op pulse, no RegWrite.
REQ-018 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; ->FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01; PCEn = Zero for 04h, ~Zero for 05h (combinational in Zero); ->FETCH.
REQ-020 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=010; ->ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; ->FETCH.
REQ-021 JUMP: PCSrc=10, PCEn=1; ->FETCH.
REQ-022 Unlisted outputs SHALL be 0 in every state; MemWrite, RegWrite, IRWrite, PCEn never asserted outside the states above.
REQ-023 A wait counter SHALL clear on entering any mem_req state and increment each cycle mem_ready=0 there; on reaching MEM_TIMEOUT without mem_ready, pulse bus_err, deassert mem_req next cycle, go to FETCH (no IRWrite/PCEn/MemWrite commit; FETCH timeout retries fetch).
REQ-024 mem_ready while mem_req=0 SHALL be ignored; mem_ready in same cycle counter hits MEM_TIMEOUT SHALL complete normally (no bus_err).

Reset
REQ-025 reset=0 SHALL asynchronously force state FETCH, wait counter 0, counters 0, illegal_op=bus_err=0.
REQ-026 Reset mid-access SHALL abandon the access; first cycle after release is FETCH with mem_req=1.
REQ-027 During reset, all strobe outputs (MemWrite, RegWrite, IRWrite, PCEn) SHALL be 0.

Configuration
REQ-028 Macro MC_CTRL_PERF_EN SHALL select performance counters.
REQ-029 Defined: cyc_cnt increments every cycle out of reset; instr_cnt increments on each FETCH->DECODE transition; both wrap modulo 2^PERF_W. Undefined: counters and ports absent, FSM behaviour identical.

Verification
REQ-030 lw (OPCode 23h), mem_ready=1 on first request cycle -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5.
REQ-031 add (00h/20h) with fetch mem_ready delayed 3 cycles -> IRWrite/PCEn single pulse in 4th FETCH cycle; ALUControl=010 in EXECUTE; RegWrite in ALUWB.
REQ-032 bne (05h) Zero=0 -> PCEn=1, PCSrc=01 in BRANCH; beq (04h) Zero=0 -> PCEn=0.
REQ-033 sw with mem_ready held 0, MEM_TIMEOUT=4 -> bus_err pulse after 4 MEMWRITE cycles, then FETCH; no instruction advance.
REQ-034 OPCode 3Fh -> illegal_op pulse in DECODE, next state FETCH, no RegWrite/MemWrite.
REQ-035 With MC_CTRL_PERF_EN, 3 instructions from reset -> instr_cnt=3; reset=0 mid-MEMREAD -> counters 0, FETCH after release.
